// File: rtl/switch_receiver.sv
// AXIS egress sink: writes accepted frames into the frame buffer and pushes {end_ptr, tdest} on commit.
// Optional statistics counters are enabled with `define SWITCH_RECEIVER_STATS_EN.
package switch_receiver_pkg;
  localparam int unsigned AXIS_DEST_WIDTH = 4;

  typedef struct packed {
    logic [15:0]                tdata;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic                       tvalid;
    logic                       tlast;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;
endpackage

module switch_receiver
  import switch_receiver_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 11,
  parameter int unsigned TIMEOUT_CTR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  axis_d_source_t        ingress_source,
  output axis_d_sink_t          ingress_sink,
  input  logic [ADDR_WIDTH:0]   frame_rptr,
  output logic [ADDR_WIDTH:0]   frame_waddr,
  output logic [15:0]           frame_wdata,
  output logic                  frame_wen,
  input  logic                  sideband_full,
  output logic [19:0]           sideband_wdata,
  output logic                  sideband_wen,
  output logic [15:0]           frames_ok,
  output logic [15:0]           frames_dropped
);
  localparam int unsigned PW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t                     state;
  logic [PW-1:0]              wptr;
  logic [PW-1:0]              start_ptr;
  logic [PW-1:0]              wptr_inc;
  logic [AXIS_DEST_WIDTH-1:0] dest;
  logic [TIMEOUT_CTR_WIDTH:0] timeout_ctr;
  logic                       full;
  logic                       tready;
  logic                       accept;
  logic                       timed_out;

  function automatic logic [19:0] sb_entry(input logic [PW-1:0] end_ptr,
                                           input logic [AXIS_DEST_WIDTH-1:0] d);
    logic [19:0] e;
    e = '0;
    e[AXIS_DEST_WIDTH +: PW]  = end_ptr;
    e[AXIS_DEST_WIDTH-1:0]    = d;
    return e;
  endfunction

  assign full = (wptr[ADDR_WIDTH] != frame_rptr[ADDR_WIDTH]) &&
                (wptr[ADDR_WIDTH-1:0] == frame_rptr[ADDR_WIDTH-1:0]);
  assign accept    = ingress_source.tvalid & tready;
  assign timed_out = timeout_ctr[TIMEOUT_CTR_WIDTH];
  assign wptr_inc  = wptr + 1'b1;

  // tready never depends on tvalid; held low while reset is asserted
  always_comb begin
    tready = 1'b0;
    case (state)
      IDLE:        tready = ~full & ~sideband_full;
      RECV, DRAIN: tready = 1'b1;
      default:     tready = 1'b0;
    endcase
    if (!reset) tready = 1'b0;
  end

  assign ingress_sink.tready = tready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wptr           <= '0;
      start_ptr      <= '0;
      dest           <= '0;
      timeout_ctr    <= '0;
      frame_wen      <= 1'b0;
      frame_waddr    <= '0;
      frame_wdata    <= '0;
      sideband_wen   <= 1'b0;
      sideband_wdata <= '0;
    end else begin
      frame_wen    <= 1'b0;
      sideband_wen <= 1'b0;
      case (state)
        IDLE: begin
          timeout_ctr <= '0;
          if (accept) begin
            start_ptr   <= wptr;
            dest        <= ingress_source.tdest;
            frame_wen   <= 1'b1;
            frame_waddr <= wptr;
            frame_wdata <= ingress_source.tdata;
            wptr        <= wptr_inc;
            if (ingress_source.tlast) begin
              sideband_wen   <= 1'b1;
              sideband_wdata <= sb_entry(wptr_inc, ingress_source.tdest);
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          // Timeout wins over a coincident beat; a non-last beat then drains the rest
          if (timed_out) begin
            wptr        <= start_ptr;
            timeout_ctr <= '0;
            state       <= (accept && !ingress_source.tlast) ? DRAIN : IDLE;
          end else if (accept) begin
            timeout_ctr <= '0;
            if (full) begin
              wptr  <= start_ptr;
              state <= ingress_source.tlast ? IDLE : DRAIN;
            end else begin
              frame_wen   <= 1'b1;
              frame_waddr <= wptr;
              frame_wdata <= ingress_source.tdata;
              wptr        <= wptr_inc;
              if (ingress_source.tlast) begin
                sideband_wen   <= 1'b1;
                sideband_wdata <= sb_entry(wptr_inc, dest);
                state          <= IDLE;
              end
            end
          end else if (!ingress_source.tvalid) begin
            timeout_ctr <= timeout_ctr + 1'b1;
          end
        end
        DRAIN: begin
          if (accept) begin
            timeout_ctr <= '0;
            if (ingress_source.tlast) state <= IDLE;
          end else if (timed_out) begin
            timeout_ctr <= '0;
            state       <= IDLE;
          end else if (!ingress_source.tvalid) begin
            timeout_ctr <= timeout_ctr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SWITCH_RECEIVER_STATS_EN
  logic commit;
  logic drop;

  assign commit = accept & ingress_source.tlast &
                  ((state == IDLE) | ((state == RECV) & ~timed_out & ~full));
  assign drop   = (state == RECV) & (timed_out | (accept & full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      if (commit && frames_ok != '1)    frames_ok      <= frames_ok + 1'b1;
      if (drop && frames_dropped != '1) frames_dropped <= frames_dropped + 1'b1;
    end
  end
`else
  assign frames_ok      = '0;
  assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_switch_receiver.sv
// Directed bench for switch_receiver: commits, back-to-back, timeout, overflow, sideband stall, reset.
module tb_switch_receiver;
  import switch_receiver_pkg::*;

  localparam int unsigned AW = 11;
`ifdef SWITCH_RECEIVER_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic           clk;
  logic           reset;
  axis_d_source_t src;
  axis_d_sink_t   snk;
  logic [AW:0]    frame_rptr;
  logic [AW:0]    frame_waddr;
  logic [15:0]    frame_wdata;
  logic           frame_wen;
  logic           sideband_full;
  logic [19:0]    sideband_wdata;
  logic           sideband_wen;
  logic [15:0]    frames_ok;
  logic [15:0]    frames_dropped;

  int checks   = 0;
  int failures = 0;

  logic [AW:0]  wr_addr[$];
  logic [15:0]  wr_data[$];
  logic [19:0]  sb_word[$];
  logic         sb_with_wen[$];

  switch_receiver #(.ADDR_WIDTH(AW), .TIMEOUT_CTR_WIDTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .ingress_source (src),
    .ingress_sink   (snk),
    .frame_rptr     (frame_rptr),
    .frame_waddr    (frame_waddr),
    .frame_wdata    (frame_wdata),
    .frame_wen      (frame_wen),
    .sideband_full  (sideband_full),
    .sideband_wdata (sideband_wdata),
    .sideband_wen   (sideband_wen),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (frame_wen) begin
      wr_addr.push_back(frame_waddr);
      wr_data.push_back(frame_wdata);
    end
    if (sideband_wen) begin
      sb_word.push_back(sideband_wdata);
      sb_with_wen.push_back(frame_wen);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    sb_word.delete();
    sb_with_wen.delete();
  endtask

  task automatic idle(input int n);
    src.tvalid = 1'b0;
    src.tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [3:0] dst, input logic last);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    src.tdata  = d;
    src.tdest  = dst;
    src.tvalid = 1'b1;
    src.tlast  = last;
    while (!acc && n < 40) begin
      #1 acc = snk.tready;
      @(negedge clk);
      n++;
    end
    check("beat_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [3:0] dst, input int n, input logic [15:0] d0);
    for (int i = 0; i < n; i++) send_beat(d0 + 16'(i), dst, i == n - 1);
    src.tvalid = 1'b0;
    src.tlast  = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int addr0, input int n, input logic [15:0] d0,
                              input int n_sb, input logic [19:0] sb0, input logic [19:0] sb1);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr[i]), 32'((addr0 + i) % 4096));
      check({tag, "_data"}, 32'(wr_data[i]), 32'(d0 + 16'(i)));
    end
    check({tag, "_nsb"}, 32'(sb_word.size()), 32'(n_sb));
    for (int i = 0; i < n_sb && i < sb_word.size(); i++) begin
      check({tag, "_sb"}, 32'(sb_word[i]), 32'((i == 0) ? sb0 : sb1));
      check({tag, "_sb_with_wen"}, 32'(sb_with_wen[i]), 32'd1);
    end
    clear_logs();
  endtask

  initial begin
    reset         = 1'b0;
    src           = '0;
    frame_rptr    = '0;
    sideband_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tready", 32'(snk.tready), 32'd0);
    check("rst_wen", 32'(frame_wen), 32'd0);
    check("rst_waddr", 32'(frame_waddr), 32'd0);
    check("rst_sbwen", 32'(sideband_wen), 32'd0);
    check("rst_sbdata", 32'(sideband_wdata), 32'd0);
    check("rst_ok", 32'(frames_ok), 32'd0);
    check("rst_dropped", 32'(frames_dropped), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();

    // 4-beat frame, dest 3, from wptr 0
    send_frame(4'd3, 4, 16'hA000);
    idle(2);
    expect_frame("four_beat", 0, 4, 16'hA000, 1, 20'h00043, 20'h0);

    // 6-beat frame to wptr 10, then single-beat frame back-to-back
    send_frame(4'd1, 6, 16'hA100);
    send_beat(16'hA106, 4'd5, 1'b1);
    idle(2);
    expect_frame("b2b_single", 4, 7, 16'hA100, 2, 20'h000A1, 20'h000B5);

    // Stall of 8 idle cycles after beat 2 drops the frame
    send_beat(16'hC000, 4'd2, 1'b0);
    send_beat(16'hC001, 4'd2, 1'b0);
    idle(8);
    send_beat(16'hC002, 4'd2, 1'b1);
    idle(2);
    expect_frame("timeout_drop", 11, 2, 16'hC000, 0, 20'h0, 20'h0);
    check("timeout_dropped_cnt", 32'(frames_dropped), 32'(STATS * 1));
    check("timeout_ok_cnt", 32'(frames_ok), 32'(STATS * 3));

    // Stall of 7 cycles survives; frame rewritten at the old start
    send_beat(16'hD000, 4'd7, 1'b0);
    send_beat(16'hD001, 4'd7, 1'b0);
    idle(7);
    send_beat(16'hD002, 4'd7, 1'b1);
    idle(2);
    expect_frame("stall7_ok", 11, 3, 16'hD000, 1, 20'h000E7, 20'h0);

    // Sideband full blocks frame start
    sideband_full = 1'b1;
    src.tdata  = 16'hE000;
    src.tdest  = 4'd4;
    src.tlast  = 1'b0;
    src.tvalid = 1'b1;
    #1 check("sbfull_tready", 32'(snk.tready), 32'd0);
    repeat (3) @(negedge clk);
    check("sbfull_nwr", 32'(wr_addr.size()), 32'd0);
    sideband_full = 1'b0;
    send_frame(4'd4, 3, 16'hE000);
    idle(2);
    expect_frame("sbfull_release", 14, 3, 16'hE000, 1, 20'h00114, 20'h0);

    // Buffer holds 2046 unread entries: 2 beats fit, rest drained
    frame_rptr = 12'd2067;
    send_frame(4'd9, 5, 16'hF000);
    idle(2);
    expect_frame("overflow", 17, 2, 16'hF000, 0, 20'h0, 20'h0);
    send_frame(4'd10, 2, 16'hF100);
    idle(2);
    expect_frame("fill_exact", 17, 2, 16'hF100, 1, 20'h0013A, 20'h0);
    src.tdata  = 16'hF200;
    src.tdest  = 4'd11;
    src.tlast  = 1'b1;
    src.tvalid = 1'b1;
    #1 check("full_tready", 32'(snk.tready), 32'd0);
    repeat (2) @(negedge clk);
    check("full_nwr", 32'(wr_addr.size()), 32'd0);
    frame_rptr = 12'd19;
    send_frame(4'd11, 1, 16'hF200);
    idle(2);
    expect_frame("after_read", 19, 1, 16'hF200, 1, 20'h0014B, 20'h0);
    check("stats_ok", 32'(frames_ok), 32'(STATS * 7));
    check("stats_dropped", 32'(frames_dropped), 32'(STATS * 2));

    // Reset mid-frame after 3 beats
    send_beat(16'h5000, 4'd12, 1'b0);
    send_beat(16'h5001, 4'd12, 1'b0);
    send_beat(16'h5002, 4'd12, 1'b0);
    src.tvalid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_wen", 32'(frame_wen), 32'd0);
    check("midrst_waddr", 32'(frame_waddr), 32'd0);
    check("midrst_wdata", 32'(frame_wdata), 32'd0);
    check("midrst_sbdata", 32'(sideband_wdata), 32'd0);
    check("midrst_tready", 32'(snk.tready), 32'd0);
    check("midrst_ok", 32'(frames_ok), 32'd0);
    repeat (2) @(negedge clk);
    frame_rptr = '0;
    reset      = 1'b1;
    clear_logs();
    send_frame(4'd2, 1, 16'h1234);
    idle(2);
    expect_frame("post_reset", 0, 1, 16'h1234, 1, 20'h00012, 20'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
